// File: rtl/checkpoint_monitor.sv
// checkpoint_monitor
//
// On-chip observer for the 16-bit firmware checkpoint bus (mprj_io[31:16]).
// The bus is debounced. A start marker arms a run and an end marker closes it.
// Every distinct accepted value in between is timestamped into a small FIFO.
// The start-to-end latency of the last completed run is held for readback.
//
// Ports:
//   wb_clk_i        clock, all logic on the rising edge
//   wb_rst_i        asynchronous active-high reset
//   checkbits_i     checkpoint bus input
//   enable_i        monitor enable; low returns to IDLE
//   log_valid_o     FIFO head valid
//   log_data_o      {value[15:0], timestamp[CNT_W-1:0]} at FIFO head
//   log_ready_i     consumer pop (effective when log_valid_o is high)
//   latency_o       cycles from start event to end event of last completed run
//   latency_valid_o high while in DONE
//   overflow_o      sticky flag: a log entry was dropped on a full FIFO
//   state_o         00 IDLE, 01 RUN, 10 DONE
module checkpoint_monitor #(
    parameter logic [15:0] START_MARK    = 16'hAB40,
    parameter logic [15:0] END_MARK      = 16'hAB51,
    parameter int          STABLE_CYCLES = 4,
    parameter int          FIFO_DEPTH    = 8,
    parameter int          CNT_W         = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [15:0]         checkbits_i,
    input  logic                enable_i,
    output logic                log_valid_o,
    output logic [16+CNT_W-1:0] log_data_o,
    input  logic                log_ready_i,
    output logic [CNT_W-1:0]    latency_o,
    output logic                latency_valid_o,
    output logic                overflow_o,
    output logic [1:0]          state_o
);

    localparam int SC_W  = $clog2(STABLE_CYCLES + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 16 + CNT_W;
    localparam logic [SC_W-1:0] STAB_MAX = SC_W'(STABLE_CYCLES);
    localparam logic [AW:0]     DEPTH_C  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [15:0]      in_q;
    logic [SC_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic [15:0]      acc_q;
    logic [CNT_W-1:0] ts_q, ts_d, ts_inc;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic             lat_valid_q;
    logic             overflow_q, overflow_d;

    logic             event_w;
    logic             start_w;
    logic             run_evt_w;
    logic             push_w;
    logic             lat_ld_w;
    logic [ENT_W-1:0] push_data_w;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      fifo_cnt;
    logic             fifo_full, fifo_empty;
    logic             pop_w, push_ok_w, drop_w;

    // Debounce. stab_cnt counts samples of the current in_q value including
    // the first. Saturation at STABLE_CYCLES means a value loaded on edge k is
    // accepted on edge k+STABLE_CYCLES. Comparing against acc suppresses
    // repeats, and it also suppresses a glitch returning to the accepted value.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (checkbits_i != in_q) begin
            stab_cnt_d = SC_W'(1);
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + SC_W'(1);
        end
    end

    assign event_w = (stab_cnt_q == STAB_MAX) && (in_q != acc_q);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            in_q       <= '0;
            stab_cnt_q <= '0;
            acc_q      <= '0;
        end else begin
            in_q       <= checkbits_i;
            stab_cnt_q <= stab_cnt_d;
            if (event_w) begin
                acc_q <= in_q;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. Dropping enable takes priority over any event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable_i && event_w && in_q == START_MARK) state_d = S_RUN;
            S_RUN: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (event_w && in_q == END_MARK) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: if (!enable_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. The logged timestamp is the number of edges since the
    // start edge. The start entry is 0, and an event N edges later logs N.
    assign ts_inc = (ts_q == {CNT_W{1'b1}}) ? ts_q : ts_q + CNT_W'(1);

    always_comb begin
        start_w     = 1'b0;
        run_evt_w   = 1'b0;
        lat_ld_w    = 1'b0;
        ts_d        = ts_q;
        push_data_w = {in_q, ts_inc};
        case (state_q)
            S_IDLE: begin
                start_w = enable_i && event_w && (in_q == START_MARK);
                if (start_w) begin
                    ts_d        = '0;
                    push_data_w = {START_MARK, {CNT_W{1'b0}}};
                end
            end
            S_RUN: begin
                ts_d      = ts_inc;
                run_evt_w = enable_i && event_w;
                lat_ld_w  = run_evt_w && (in_q == END_MARK);
            end
            default: ;
        endcase
    end

    assign push_w = start_w || run_evt_w;

    // FIFO. Pointers carry one extra bit to tell full from empty.
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (fifo_cnt == DEPTH_C);
    assign pop_w      = !fifo_empty && log_ready_i;
    assign push_ok_w  = push_w && (!fifo_full || pop_w);
    assign drop_w     = push_w && !push_ok_w;

    // A drop on the start push itself still flags overflow.
    always_comb begin
        overflow_d = overflow_q;
        if (start_w) overflow_d = 1'b0;
        if (drop_w)  overflow_d = 1'b1;
    end

    assign latency_d = lat_ld_w ? ts_inc : latency_q;

    always_ff @(posedge wb_clk_i) begin
        if (push_ok_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_w;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ts_q        <= '0;
            latency_q   <= '0;
            lat_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push_ok_w) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_w)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            ts_q        <= ts_d;
            latency_q   <= latency_d;
            lat_valid_q <= (state_d == S_DONE);
            overflow_q  <= overflow_d;
        end
    end

    assign log_valid_o     = !fifo_empty;
    assign log_data_o      = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign latency_o       = latency_q;
    assign latency_valid_o = lat_valid_q;
    assign overflow_o      = overflow_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Scoreboard bench for checkpoint_monitor (default parameters).
// Stimulus pushes hand-computed log entries into exp_q. A separate monitor
// pops and compares whenever the DUT presents a popped entry.
module tb_checkpoint_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic        en;
    logic        lvalid;
    logic [47:0] ldata;
    logic        lready;
    logic [31:0] lat;
    logic        lat_v;
    logic        ovf;
    logic [1:0]  st;

    int npass  = 0;
    int ntotal = 0;
    logic [47:0] exp_q[$];

    checkpoint_monitor dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .checkbits_i     (bus),
        .enable_i        (en),
        .log_valid_o     (lvalid),
        .log_data_o      (ldata),
        .log_ready_i     (lready),
        .latency_o       (lat),
        .latency_valid_o (lat_v),
        .overflow_o      (ovf),
        .state_o         (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [15:0] v, input int n);
        bus = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_entry(input logic [15:0] v, input logic [31:0] ts);
        exp_q.push_back({v, ts});
    endtask

    // Monitor: a pop happens on the next rising edge when valid and ready.
    always @(negedge clk) begin
        if (!rst && lvalid && lready) begin
            if (exp_q.size() == 0) begin
                ntotal++;
                $display("FAIL unexpected_entry: got %0h, none expected", ldata);
            end else begin
                chk("log_entry", {16'h0, ldata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bus = 16'h0; en = 1'b0; lready = 1'b1;
        #12;
        chk("rst_log_valid", {63'h0, lvalid}, 64'h0);
        chk("rst_latency", {32'h0, lat}, 64'h0);
        chk("rst_lat_valid", {63'h0, lat_v}, 64'h0);
        chk("rst_overflow", {63'h0, ovf}, 64'h0);
        chk("rst_state", {62'h0, st}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        en  = 1'b1;

        // Non-start value in IDLE logs nothing.
        drive(16'h1111, 8);
        chk("idle_state", {62'h0, st}, 64'h0);
        chk("idle_no_log", {63'h0, lvalid}, 64'h0);

        // Abort in RUN: no latency update.
        expect_entry(16'hAB40, 0);
        expect_entry(16'h0777, 10);
        drive(16'hAB40, 10);
        drive(16'h0777, 6);
        chk("abort_pre_state", {62'h0, st}, 64'h1);
        en = 1'b0;
        drive(16'h0777, 2);
        chk("abort_state", {62'h0, st}, 64'h0);
        chk("abort_latency", {32'h0, lat}, 64'h0);
        chk("abort_lat_valid", {63'h0, lat_v}, 64'h0);

        // Basic run.
        en = 1'b1;
        expect_entry(16'hAB40, 0);
        expect_entry(16'h021B, 10);
        expect_entry(16'hAB51, 30);
        drive(16'hAB40, 10);
        drive(16'h021B, 20);
        drive(16'hAB51, 6);
        chk("basic_state", {62'h0, st}, 64'h2);
        chk("basic_latency", {32'h0, lat}, 64'd30);
        chk("basic_lat_valid", {63'h0, lat_v}, 64'h1);
        drive(16'h5555, 8);   // ignored in DONE
        chk("done_state", {62'h0, st}, 64'h2);
        chk("done_latency", {32'h0, lat}, 64'd30);
        en = 1'b0;
        drive(16'h5555, 2);
        chk("done_exit_state", {62'h0, st}, 64'h0);
        chk("done_exit_lat_valid", {63'h0, lat_v}, 64'h0);
        chk("done_exit_latency", {32'h0, lat}, 64'd30);

        // Rearm, 100-cycle run.
        en = 1'b1;
        expect_entry(16'hAB40, 0);
        expect_entry(16'hAB51, 100);
        drive(16'hAB40, 100);
        drive(16'hAB51, 6);
        chk("rearm_latency", {32'h0, lat}, 64'd100);
        chk("rearm_lat_valid", {63'h0, lat_v}, 64'h1);
        en = 1'b0;
        drive(16'hAB51, 2);

        // Glitch filter inside RUN.
        en = 1'b1;
        expect_entry(16'hAB40, 0);
        expect_entry(16'h0100, 10);
        expect_entry(16'h0200, 30);
        expect_entry(16'hAB51, 40);
        drive(16'hAB40, 10);
        drive(16'h0100, 10);
        drive(16'h1234, 3);
        drive(16'h0100, 7);
        drive(16'h0200, 10);
        drive(16'hAB51, 6);
        chk("glitch_latency", {32'h0, lat}, 64'd40);
        chk("glitch_state", {62'h0, st}, 64'h2);
        en = 1'b0;
        drive(16'hAB51, 2);

        // Overflow: 10 events after start with no consumer.
        lready = 1'b0;
        en = 1'b1;
        expect_entry(16'hAB40, 0);
        for (int i = 1; i <= 7; i++) expect_entry(16'(i), 32'(6 * i));
        drive(16'hAB40, 6);
        for (int i = 1; i <= 10; i++) drive(16'(i), 6);
        chk("ovf_flag", {63'h0, ovf}, 64'h1);
        chk("ovf_state", {62'h0, st}, 64'h1);
        chk("ovf_valid", {63'h0, lvalid}, 64'h1);
        lready = 1'b1;
        drive(16'h000A, 12);
        chk("ovf_drained", {63'h0, lvalid}, 64'h0);
        chk("ovf_sticky", {63'h0, ovf}, 64'h1);
        en = 1'b0;
        drive(16'h000A, 2);
        en = 1'b1;
        expect_entry(16'hAB40, 0);
        drive(16'hAB40, 6);
        chk("ovf_cleared", {63'h0, ovf}, 64'h0);

        // Push and pop in the same cycle at full.
        en = 1'b0;
        drive(16'h0F0F, 6);
        en = 1'b1;
        lready = 1'b0;
        expect_entry(16'hAB40, 0);
        for (int j = 1; j <= 7; j++) expect_entry(16'h0010 + 16'(j), 32'(6 * j));
        expect_entry(16'h0099, 48);
        drive(16'hAB40, 6);
        for (int j = 1; j <= 7; j++) drive(16'h0010 + 16'(j), 6);
        drive(16'h0099, 4);
        lready = 1'b1;        // covers exactly the accepting edge of 0x0099
        @(posedge clk); #1;
        lready = 1'b0;
        chk("full_pp_no_ovf", {63'h0, ovf}, 64'h0);
        chk("full_pp_valid", {63'h0, lvalid}, 64'h1);
        lready = 1'b1;
        drive(16'h0099, 12);
        chk("full_pp_drained", {63'h0, lvalid}, 64'h0);

        // Asynchronous reset mid-run with 3 entries queued.
        en = 1'b0;
        drive(16'h0099, 2);
        en = 1'b1;
        lready = 1'b0;
        drive(16'hAB40, 6);
        drive(16'h0021, 6);
        drive(16'h0022, 6);
        chk("pre_rst_state", {62'h0, st}, 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_log_valid", {63'h0, lvalid}, 64'h0);
        chk("arst_log_data", {16'h0, ldata}, 64'h0);
        chk("arst_latency", {32'h0, lat}, 64'h0);
        chk("arst_lat_valid", {63'h0, lat_v}, 64'h0);
        chk("arst_overflow", {63'h0, ovf}, 64'h0);
        chk("arst_state", {62'h0, st}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        lready = 1'b1;
        drive(16'h0022, 10);
        chk("post_rst_no_log", {63'h0, lvalid}, 64'h0);
        chk("post_rst_state", {62'h0, st}, 64'h0);

        chk("exp_queue_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
